mem_loader: RTL

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// Boot-time memory loader: parses a stream of header/payload words, writes
// payloads into instruction or data memory, and releases the core from reset
// on a run command. Writes are registered and appear the cycle after acceptance.
module mem_loader #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_data,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_data,
    output logic              cpu_rst,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [1:0] {StHdr, StLoad, StRun} state_e;

    localparam logic [ADDR_W-1:0] AddrOne = 1;

    state_e              state_q, state_d;
    logic                tgt_q, tgt_d;      // 0: instruction memory, 1: data memory
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          rem_q, rem_d;      // payload words left minus one
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_data_q, im_data_d;
    logic                dm_we_q, dm_we_d;
    logic [ADDR_W-1:0]   dm_addr_q, dm_addr_d;
    logic [31:0]         dm_data_q, dm_data_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                err_q, err_d;
    logic [31:0]         checksum_q, checksum_d;
    logic                accept;

    // Ready only while parsing headers or payload; reset wins over any handshake.
    assign in_ready = !rst && ((state_q == StHdr) || (state_q == StLoad));
    assign accept   = in_valid && in_ready;

    // Next-state: header decode, payload write scheduling and checksum.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_data_d  = im_data_q;
        dm_we_d    = 1'b0;
        dm_addr_d  = dm_addr_q;
        dm_data_d  = dm_data_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = err_q;
        checksum_d = checksum_q;

        unique case (state_q)
            StHdr: begin
                if (accept) begin
                    unique case (in_data[31:30])
                        2'b00, 2'b01: begin
                            tgt_d   = in_data[30];
                            addr_d  = in_data[9 +: ADDR_W];
                            rem_d   = in_data[8:0];
                            state_d = StLoad;
                        end
                        2'b10: begin
                            cpu_rst_d = 1'b0;
                            state_d   = StRun;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            StLoad: begin
                if (accept) begin
                    checksum_d = checksum_q ^ in_data;
                    if (tgt_q) begin
                        dm_we_d   = 1'b1;
                        dm_addr_d = addr_q;
                        dm_data_d = in_data;
                    end else begin
                        im_we_d   = 1'b1;
                        im_addr_d = addr_q;
                        im_data_d = in_data;
                    end
                    // Natural overflow gives the modulo-depth wrap.
                    addr_d = addr_q + AddrOne;
                    if (rem_q == 9'd0) begin
                        state_d = StHdr;
                    end else begin
                        rem_d = rem_q - 9'd1;
                    end
                end
            end
            StRun: begin
                // Terminal until reset.
            end
            default: begin
                state_d = StHdr;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHdr;
            tgt_q      <= 1'b0;
            addr_q     <= '0;
            rem_q      <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_data_q  <= '0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_data_q  <= '0;
            cpu_rst_q  <= 1'b1;
            err_q      <= 1'b0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_data_q  <= im_data_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_data_q  <= dm_data_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
            checksum_q <= checksum_d;
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_data  = im_data_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_data  = dm_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign err      = err_q;
    assign checksum = checksum_q;

endmodule
